pipe_stall_ctrl: RTL and testbench

Pipeline interlock unit that drives the stall input of the PC register and the IF/ID register: it produces `wpcir` (1 = hold PC and IF/ID) and `bubble` (1 = load a NOP into ID/EX). It detects load-use hazards between the ID and EX stages and tracks a multi-cycle multiply/divide unit with an internal busy state machine. It sits in the ID stage beside the register-file read and the forwarding muxes.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/md_busy_timer.sv | 55 +++++
 rtl/pipe_stall_ctrl.sv | 83 ++++++++
 tb/tb_pipe_stall_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline interlock unit.
package pipe_pkg;

   // Mul/div occupancy state
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   // Register-file index width and the hardwired-zero register
   localparam int               REG_W    = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/md_busy_timer.sv
// Mul/div occupancy tracker: IDLE/BUSY FSM with a down-counter.
// A start in IDLE loads MD_LATENCY; busy stays high for exactly
// MD_LATENCY cycles, done marks the last of them.
module md_busy_timer
   import pipe_pkg::*;
#(
   parameter int MD_LATENCY = 8,
   parameter int CNT_W      = 8
) (
   input  logic clock,
   input  logic resetn,
   input  logic start,
   output logic busy,
   output logic done
);

   localparam logic [CNT_W-1:0] LAT = CNT_W'(MD_LATENCY);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   md_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;

   // FSM and counter; reset abandons any operation in flight
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= BUSY;
                  r_cnt   <= LAT;
               end
            end
            BUSY: begin
               if (r_cnt == ONE) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt - ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign busy = (r_state == BUSY);
   assign done = (r_state == BUSY) && (r_cnt == ONE);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline interlock: load-use detection, mul/div busy tracking and
// the combined PC / IF-ID hold (wpcir) and ID/EX bubble.
// Optional build macro PIPE_STALL_STATS_EN adds a saturating
// stall-cycle counter on port stall_count.
module pipe_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_LATENCY = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [REG_W-1:0] ex_rn,
   input  logic             id_md_start,
   input  logic             id_md_read,
   output logic             wpcir,
   output logic             bubble,
   output logic             md_busy,
   output logic             md_go
`ifdef PIPE_STALL_STATS_EN
   ,
   output logic [31:0]      stall_count
`endif
);

   logic w_lu;
   logic w_mdh;
   logic w_stall;
   logic w_busy;
   logic w_md_done;

   // Load-use: EX load whose non-zero destination is read in ID
   always_comb begin
      w_lu = ex_wreg && ex_m2reg && (ex_rn != REG_ZERO) &&
             ((id_use_rs && (id_rs == ex_rn)) ||
              (id_use_rt && (id_rt == ex_rn)));
   end

   // Mul/div hazard: another mult/div or HI/LO read while unit is busy
   always_comb begin
      w_mdh = w_busy && (id_md_start || id_md_read);
   end

   // Outputs forced low while reset is held, independent of inputs
   assign w_stall = resetn && (w_lu || w_mdh);
   assign wpcir   = w_stall;
   assign bubble  = w_stall;
   assign md_busy = w_busy;
   // Start only from IDLE and never under a load-use, so never with wpcir
   assign md_go   = resetn && !w_busy && id_md_start && !w_lu;

   md_busy_timer #(
      .MD_LATENCY (MD_LATENCY),
      .CNT_W      (CNT_W)
   ) u_md_timer (
      .clock  (clock),
      .resetn (resetn),
      .start  (md_go),
      .busy   (w_busy),
      .done   (w_md_done)
   );

`ifdef PIPE_STALL_STATS_EN
   logic [31:0] r_stall_count;

   // Count stalled cycles, saturating at all-ones
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         r_stall_count <= '0;
      else if (w_stall && (r_stall_count != 32'hFFFF_FFFF))
         r_stall_count <= r_stall_count + 32'd1;
   end

   assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboarded directed bench for pipe_stall_ctrl (MD_LATENCY = 8).
// Expected {wpcir,bubble,md_busy,md_go} is queued per driven cycle;
// a monitor pops and compares on the falling edge.
module tb_pipe_stall_ctrl;

   logic       clock;
   logic       resetn;
   logic [4:0] id_rs, id_rt, ex_rn;
   logic       id_use_rs, id_use_rt, ex_wreg, ex_m2reg;
   logic       id_md_start, id_md_read;
   logic       wpcir, bubble, md_busy, md_go;
`ifdef PIPE_STALL_STATS_EN
   logic [31:0] stall_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] exp_q[$];
   string      nm_q[$];

   pipe_stall_ctrl #(.MD_LATENCY(8), .CNT_W(8)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .ex_wreg     (ex_wreg),
      .ex_m2reg    (ex_m2reg),
      .ex_rn       (ex_rn),
      .id_md_start (id_md_start),
      .id_md_read  (id_md_read),
      .wpcir       (wpcir),
      .bubble      (bubble),
      .md_busy     (md_busy),
      .md_go       (md_go)
`ifdef PIPE_STALL_STATS_EN
      ,
      .stall_count (stall_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: compare one queued expectation per falling edge
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         logic [3:0] e;
         logic [3:0] g;
         string      n;
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         g = {wpcir, bubble, md_busy, md_go};
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL %s: {wpcir,bubble,busy,go} got %b want %b", n, g, e);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [3:0] e, input string n);
      exp_q.push_back(e);
      nm_q.push_back(n);
   endtask

   task automatic idle_in();
      id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      ex_wreg = 0; ex_m2reg = 0; ex_rn = 0;
      id_md_start = 0; id_md_read = 0;
   endtask

   task automatic ex_load(input logic [4:0] rn);
      ex_wreg = 1; ex_m2reg = 1; ex_rn = rn;
   endtask

   initial begin
      resetn = 0;
      idle_in();
      repeat (2) tick();

      // Reset holds outputs low even with hazardous inputs
      ex_load(5); id_rs = 5; id_use_rs = 1; id_md_start = 1;
      push(4'b0000, "reset_hold");
      tick();

      // First cycle after release: PC advances
      resetn = 1; idle_in(); id_md_read = 1;
      push(4'b0000, "first_cycle");
      tick();

      idle_in(); ex_load(5); id_rs = 5; id_use_rs = 1;
      push(4'b1100, "lu_rs");
      tick();
      ex_wreg = 0; ex_m2reg = 0; ex_rn = 0;
      push(4'b0000, "lu_clear");
      tick();

      idle_in(); ex_load(0); id_use_rs = 1; id_use_rt = 1;
      push(4'b0000, "reg0");
      tick();

      idle_in(); ex_load(5); id_rs = 5; id_rt = 6; id_use_rt = 1;
      push(4'b0000, "rt_only");
      tick();

      idle_in(); ex_load(5); id_rt = 5; id_use_rt = 1;
      push(4'b1100, "lu_rt");
      tick();

      idle_in(); ex_wreg = 1; ex_rn = 5; id_rs = 5; id_use_rs = 1;
      push(4'b0000, "alu_no_lu");
      tick();

      // Start behind load-use, accepted once lu drops
      idle_in(); ex_load(7); id_rs = 7; id_use_rs = 1; id_md_start = 1;
      push(4'b1100, "lu_beats_start");
      tick();
      idle_in(); id_rs = 7; id_use_rs = 1; id_md_start = 1;
      push(4'b0001, "start_after_lu");
      tick();

      // mflo waits 8 cycles, proceeds at T+9
      idle_in(); id_md_read = 1;
      for (int i = 0; i < 8; i++) begin
         push(4'b1110, "mflo_wait");
         tick();
      end
      push(4'b0000, "mflo_go");
      tick();

      // Back-to-back mult
      idle_in(); id_md_start = 1;
      push(4'b0001, "mult_a");
      tick();
      for (int i = 0; i < 8; i++) begin
         push(4'b1110, "b2b_wait");
         tick();
      end
      push(4'b0001, "b2b_go");
      tick();

      idle_in(); id_rs = 9; id_use_rs = 1;
      push(4'b0010, "passthru_busy");
      tick();
      idle_in(); ex_load(3); id_rs = 3; id_use_rs = 1;
      push(4'b1110, "lu_busy");
      tick();
      idle_in();
      push(4'b0010, "busy_idle_a");
      tick();
      push(4'b0010, "busy_idle_b");
      tick();

      // Counter is 4 here: reset abandons the operation
      resetn = 0; id_md_read = 1; id_md_start = 1;
      push(4'b0000, "reset_mid_busy");
      tick();
      resetn = 1; id_md_start = 0;
      push(4'b0000, "post_rst_mflo");
      tick();

      // 3 load-use stalls + 8-cycle mflo wait (stall total 11)
      for (int k = 0; k < 3; k++) begin
         idle_in(); ex_load(5'(k + 1)); id_rt = 5'(k + 1); id_use_rt = 1;
         push(4'b1100, "stat_lu");
         tick();
         idle_in();
         push(4'b0000, "stat_lu_clear");
         tick();
      end
      idle_in(); id_md_start = 1;
      push(4'b0001, "stat_start");
      tick();
      idle_in(); id_md_read = 1;
      for (int i = 0; i < 8; i++) begin
         push(4'b1110, "stat_wait");
         tick();
      end
      push(4'b0000, "stat_mflo_go");
      tick();
      idle_in();
`ifdef PIPE_STALL_STATS_EN
      n_vec++;
      if (stall_count !== 32'd11) begin
         n_err++;
         $display("FAIL stall_count: got %0d want 11", stall_count);
      end
`endif

      // Drain scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
      if (exp_q.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
